scarv_ccx_ic_arbiter: RTL

//  Two-requester to one-target arbiter for the core complex memory interface (scarv_ccx_memif).
//  - Shares one downstream port (if_mem) between instruction fetch (port 0) and data access (port 1).
//  - Typical placement: between the CPU fetch/LSU ports and the ic_router core port.
//  - Holds the selection stable while a downstream request is stalled.
//  - Returns each single-cycle response to the requester that won the grant.
//

---
 rtl/scarv_ccx_ic_pkg.sv | 14 +
 rtl/scarv_ccx_ic_arb_pick.sv | 23 ++
 rtl/scarv_ccx_ic_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/scarv_ccx_ic_pkg.sv
// rtl/scarv_ccx_ic_pkg.sv - shared types for the core complex interconnect
package scarv_ccx_ic_pkg;

  typedef enum logic {
    IC_ARB_IDLE   = 1'b0,
    IC_ARB_LOCKED = 1'b1
  } ic_arb_state_t;

  typedef logic ic_port_t;

  localparam ic_port_t IC_PORT_FETCH = 1'b0;
  localparam ic_port_t IC_PORT_DATA  = 1'b1;

endpackage

// File: rtl/scarv_ccx_ic_arb_pick.sv
// rtl/scarv_ccx_ic_arb_pick.sv - combinational two-port contention picker
module scarv_ccx_ic_arb_pick
  import scarv_ccx_ic_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic starve,
  output logic sel
);

  always_comb begin
    sel = IC_PORT_FETCH;
    if (req1 && !req0) begin
      sel = IC_PORT_DATA;
    end else if (req0 && req1) begin
      sel = RR_ENABLE ? ~last_gnt : starve;
    end
  end

endmodule

// File: rtl/scarv_ccx_ic_arbiter.sv
// rtl/scarv_ccx_ic_arbiter.sv - two-requester to one-target memif arbiter
module scarv_ccx_ic_arbiter
  import scarv_ccx_ic_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter bit RR_ENABLE = 1'b1,
  parameter int MAX_WAIT  = 7
) (
  input  logic            g_clk,
  input  logic            g_resetn,

  input  logic            if_req0_req,
  output logic            if_req0_gnt,
  input  logic [AW-1:0]   if_req0_addr,
  input  logic            if_req0_wen,
  input  logic [DW/8-1:0] if_req0_strb,
  input  logic [DW-1:0]   if_req0_wdata,
  output logic [DW-1:0]   if_req0_rdata,
  output logic            if_req0_error,

  input  logic            if_req1_req,
  output logic            if_req1_gnt,
  input  logic [AW-1:0]   if_req1_addr,
  input  logic            if_req1_wen,
  input  logic [DW/8-1:0] if_req1_strb,
  input  logic [DW-1:0]   if_req1_wdata,
  output logic [DW-1:0]   if_req1_rdata,
  output logic            if_req1_error,

  output logic            if_mem_req,
  input  logic            if_mem_gnt,
  output logic [AW-1:0]   if_mem_addr,
  output logic            if_mem_wen,
  output logic [DW/8-1:0] if_mem_strb,
  output logic [DW-1:0]   if_mem_wdata,
  input  logic [DW-1:0]   if_mem_rdata,
  input  logic            if_mem_error,

  output logic            arb_owner
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  ic_arb_state_t state_q, state_d;
  ic_port_t      sel, sel_q, pick_sel, last_gnt_q, rsp_owner_q;
  logic          rsp_valid_q, sel_req, transfer, starve;
  logic [WW-1:0] wait_cnt_q;

  assign starve = (wait_cnt_q == WAIT_MAX);

  scarv_ccx_ic_arb_pick #(
    .RR_ENABLE (RR_ENABLE)
  ) u_pick (
    .req0     (if_req0_req),
    .req1     (if_req1_req),
    .last_gnt (last_gnt_q),
    .starve   (starve),
    .sel      (pick_sel)
  );

  // sel_q doubles as the lock target: in LOCKED it is never overwritten by pick.
  always_comb begin
    sel = sel_q;
    if (state_q == IC_ARB_IDLE && (if_req0_req || if_req1_req)) begin
      sel = pick_sel;
    end
  end

  assign sel_req  = (sel == IC_PORT_DATA) ? if_req1_req : if_req0_req;
  assign transfer = sel_req && if_mem_gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IC_ARB_IDLE:   if (sel_req && !if_mem_gnt) state_d = IC_ARB_LOCKED;
      IC_ARB_LOCKED: if (!sel_req || if_mem_gnt) state_d = IC_ARB_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q     <= IC_ARB_IDLE;
      sel_q       <= IC_PORT_FETCH;
      last_gnt_q  <= IC_PORT_DATA;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= IC_PORT_FETCH;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel;
      rsp_valid_q <= transfer;
      if (transfer) begin
        last_gnt_q  <= sel;
        rsp_owner_q <= sel;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn || RR_ENABLE) begin
      wait_cnt_q <= '0;
    end else if (!if_req1_req || (transfer && sel == IC_PORT_DATA)) begin
      wait_cnt_q <= '0;
    end else if (!starve) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign if_mem_req   = sel_req;
  assign if_mem_addr  = (sel == IC_PORT_DATA) ? if_req1_addr  : if_req0_addr;
  assign if_mem_wen   = (sel == IC_PORT_DATA) ? if_req1_wen   : if_req0_wen;
  assign if_mem_strb  = (sel == IC_PORT_DATA) ? if_req1_strb  : if_req0_strb;
  assign if_mem_wdata = (sel == IC_PORT_DATA) ? if_req1_wdata : if_req0_wdata;

  assign if_req0_gnt  = (sel == IC_PORT_FETCH) && if_mem_gnt;
  assign if_req1_gnt  = (sel == IC_PORT_DATA)  && if_mem_gnt;

  assign if_req0_rdata = (rsp_valid_q && rsp_owner_q == IC_PORT_FETCH) ? if_mem_rdata : '0;
  assign if_req0_error = rsp_valid_q && rsp_owner_q == IC_PORT_FETCH && if_mem_error;
  assign if_req1_rdata = (rsp_valid_q && rsp_owner_q == IC_PORT_DATA) ? if_mem_rdata : '0;
  assign if_req1_error = rsp_valid_q && rsp_owner_q == IC_PORT_DATA && if_mem_error;

  assign arb_owner = sel;

  // A locked requester must hold req until it sees gnt.
  a_locked_req_held: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (state_q == IC_ARB_LOCKED) |-> sel_req);

endmodule
